// File: rtl/cla_seq_pkg.sv
// cla_seq_pkg: FSM state encodings and slice width for the nibble-serial CLA adder.
package cla_seq_pkg;
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_t;
   localparam int NIBBLE = 4;
endpackage

// File: rtl/cla_seq_ctrl_cla4.sv
// cla4: 4-bit carry-lookahead slice, all carries derived directly from generate/propagate.
module cla4
   import cla_seq_pkg::*;
(
   input  logic [NIBBLE-1:0] a,
   input  logic [NIBBLE-1:0] b,
   input  logic              ci,
   output logic [NIBBLE-1:0] s,
   output logic              co
);
   logic [3:0] g, p;
   logic [4:0] c;
   assign g = a & b;
   assign p = a ^ b;
   assign c[0] = ci;
   assign c[1] = g[0] | (p[0] & ci);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
   assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
               | (&p & ci);
   assign s  = p ^ c[3:0];
   assign co = c[4];
endmodule

// File: rtl/cla_seq_ctrl.sv
// cla_seq_ctrl: WIDTH-bit adder stepping one shared cla4 slice LSB->MSB, one nibble per clock.
// Define CLA_SEQ_SUB_EN to add the op_sub port (two's-complement subtract on accept).
module cla_seq_ctrl
   import cla_seq_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
`ifdef CLA_SEQ_SUB_EN
   input  logic             op_sub,
`endif
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             co,
   output logic             ovf
);
   localparam int N  = WIDTH / NIBBLE;
   localparam int IW = $clog2(N);
   localparam int SH = $clog2(NIBBLE);
   state_t            state_q, state_d;
   logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, s_q, s_d;
   logic              c_q, c_d, co_q, co_d, ovf_q, ovf_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [IW+SH-1:0]  base;
   logic [NIBBLE-1:0] sl_s;
   logic              sl_co, last;
   assign base = {idx_q, {SH{1'b0}}};
   assign last = idx_q == IW'(N - 1);
   cla4 u_cla4 (
      .a  (a_q[base +: NIBBLE]),
      .b  (b_q[base +: NIBBLE]),
      .ci (c_q),
      .s  (sl_s),
      .co (sl_co)
   );
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      idx_d   = idx_q;
      s_d     = s_q;
      co_d    = co_q;
      ovf_d   = ovf_q;
      if (state_q == ST_RUN) begin
         s_d[base +: NIBBLE] = sl_s;
         c_d                 = sl_co;
         idx_d               = last ? idx_q : idx_q + 1'b1;
         if (last) begin
            co_d    = sl_co;
            ovf_d   = (a_q[WIDTH-1] ~^ b_q[WIDTH-1]) & (a_q[WIDTH-1] ^ sl_s[NIBBLE-1]);
            state_d = ST_DONE;
         end
      end else if (start) begin
         a_d = a;
`ifdef CLA_SEQ_SUB_EN
         b_d = op_sub ? ~b : b;
         c_d = ci | op_sub;
`else
         b_d = b;
         c_d = ci;
`endif
         s_d     = '0;
         idx_d   = '0;
         state_d = ST_RUN;
      end else begin
         state_d = ST_IDLE;
      end
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= 1'b0;
         idx_q   <= '0;
         s_q     <= '0;
         co_q    <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         idx_q   <= idx_d;
         s_q     <= s_d;
         co_q    <= co_d;
         ovf_q   <= ovf_d;
      end
   end
   assign busy = state_q == ST_RUN;
   assign done = state_q == ST_DONE;
   assign s    = s_q;
   assign co   = co_q;
   assign ovf  = ovf_q;
endmodule
